// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver and held-key tracker
//
// Receives PS/2 device-to-host frames, checks odd parity and the stop bit,
// and decodes set-2 make/break sequences into a held-key bitmap.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   ps2_clk        raw PS/2 clock (asynchronous)
//   ps2_data       raw PS/2 data (asynchronous)
//   keyboard_data  held-key bitmap, [4:0] = L,D,S,A,W, [7:5] = 0
//   key_event      1-cycle pulse when keyboard_data changes
//   scan_code      last correctly received byte
//   scan_valid     1-cycle pulse when scan_code is updated
//   frame_error    1-cycle pulse on parity, stop or timeout error
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_data,
    output logic       key_event,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    localparam logic [1:0] DEC_NORMAL    = 2'd0;
    localparam logic [1:0] DEC_BREAK     = 2'd1;
    localparam logic [1:0] DEC_EXT       = 2'd2;
    localparam logic [1:0] DEC_EXT_BREAK = 2'd3;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_toggle, strobe;

    logic [1:0]    rx_state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    logic [1:0]    dec_state, dec_next;
    logic [7:0]    kd_next;
    logic          key_hit;
    logic [2:0]    key_bit;

    // Synchronisers idle high, matching the idle level of the PS/2 bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock follows the synced clock only after FILTER_LEN
    // consecutive samples that disagree with it; any agreeing sample restarts.
    assign filt_toggle = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign strobe      = filt_toggle && filt_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_toggle) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign timeout = (rx_state != RX_IDLE) && !strobe &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            scan_code   <= '0;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (rx_state == RX_IDLE || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (timeout) begin
                rx_state    <= RX_IDLE;
                frame_error <= 1'b1;
            end else if (strobe) begin
                case (rx_state)
                    RX_IDLE: begin
                        // A high line at a falling edge is not a start bit.
                        if (!dat_s2) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_bit <= dat_s2;
                        rx_state   <= RX_STOP;
                    end
                    default: begin
                        if (dat_s2 && (^{shift_reg, parity_bit})) begin
                            scan_code  <= shift_reg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        key_hit = 1'b1;
        key_bit = 3'd0;
        case (scan_code)
            8'h1D:   key_bit = 3'd0;
            8'h1C:   key_bit = 3'd1;
            8'h1B:   key_bit = 3'd2;
            8'h23:   key_bit = 3'd3;
            8'h4B:   key_bit = 3'd4;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        kd_next  = keyboard_data;
        dec_next = dec_state;
        if (frame_error) begin
            dec_next = DEC_NORMAL;
        end else if (scan_valid) begin
            if (scan_code == 8'h00 || scan_code == 8'hFF) begin
                // Keyboard overrun: release everything so motors stop.
                kd_next  = '0;
                dec_next = DEC_NORMAL;
            end else if (scan_code == 8'hE0) begin
                dec_next = DEC_EXT;
            end else if (scan_code == 8'hF0) begin
                if (dec_state == DEC_NORMAL) begin
                    dec_next = DEC_BREAK;
                end else if (dec_state == DEC_EXT) begin
                    dec_next = DEC_EXT_BREAK;
                end
            end else begin
                // Extended codes (e.g. keypad 4 vs. left arrow) never touch the bitmap.
                if (key_hit && dec_state == DEC_NORMAL) begin
                    kd_next[key_bit] = 1'b1;
                end else if (key_hit && dec_state == DEC_BREAK) begin
                    kd_next[key_bit] = 1'b0;
                end
                dec_next = DEC_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyboard_data <= '0;
            key_event     <= 1'b0;
            dec_state     <= DEC_NORMAL;
        end else begin
            keyboard_data <= kd_next;
            key_event     <= (kd_next != keyboard_data);
            dec_state     <= dec_next;
        end
    end
endmodule
